// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-size encodings,
// exception codes, FSM state type and lane/alignment helpers.
package mem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_D  = 3'b011;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;
   localparam logic [2:0] SZ_WU = 3'b110;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   function automatic int lanes(input int xlen);
      return xlen / 8;
   endfunction

   // size[1:0] is the log2 of the access width, so it selects how many low bits must be zero
   function automatic logic misaligned(input logic [2:0] sz, input logic [2:0] a);
      case (sz[1:0])
         2'b01:   return a[0];
         2'b10:   return |a[1:0];
         2'b11:   return |a;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a full aligned memory word and sign- or
// zero-extends it according to the load size.
module load_align
   import mem_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OW   = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [OW-1:0]   off,
   input  logic [2:0]      size,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] sh;

   always_comb begin
      sh = rdata >> {off, 3'b000};
      case (size)
         SZ_B:    data = XLEN'($signed(sh[7:0]));
         SZ_H:    data = XLEN'($signed(sh[15:0]));
         SZ_W:    data = XLEN'($signed(sh[31:0]));
         SZ_BU:   data = XLEN'(sh[7:0]);
         SZ_HU:   data = XLEN'(sh[15:0]);
         SZ_WU:   data = XLEN'(sh[31:0]);
         default: data = sh;
      endcase
   end

endmodule

// File: rtl/mem_stage_p.sv
// MEM pipeline stage: drives a req/ack data-memory port for loads and stores,
// passes other instructions straight to the MEM/WB register, stalls EX while busy.
module mem_stage_p
   import mem_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 15
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                ex_valid,
   output logic                ex_ready,
   input  logic                ex_load,
   input  logic                ex_store,
   input  logic [2:0]          ex_size,
   input  logic [ADDR_W-1:0]   ex_addr,
   input  logic [XLEN-1:0]     ex_alu,
   input  logic [XLEN-1:0]     ex_wdata,
   input  logic [REG_W-1:0]    ex_rd,
   input  logic                ex_regwrite,
   input  logic [31:0]         ex_pc,
   input  logic                ex_branch,
   input  logic [31:0]         ex_jaddr,
   output logic                branch_o,
   output logic [31:0]         jaddr_o,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN/8-1:0]   mem_be,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_ack,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                wb_valid,
   output logic [REG_W-1:0]    wb_rd,
   output logic                wb_we,
   output logic [XLEN-1:0]     wb_data,
   output logic [31:0]         wb_pc,
   output logic [1:0]          wb_exc,
   output state_e              dbg_state
);

   // Handshake: EX transfers a bundle on a rising edge where ex_valid && ex_ready;
   // memory holds mem_req and all mem_* fields until the edge where mem_ack is high.

   localparam int NB = lanes(XLEN);
   localparam int OW = $clog2(NB);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e            state, state_d;
   logic [CW-1:0]     cnt;
   logic              to_hit;
   logic              pass_go, mis_go, acc_go, ack_done, to_done;

   logic              lat_store, lat_regwrite;
   logic [REG_W-1:0]  lat_rd;
   logic [31:0]       lat_pc;
   logic [2:0]        lat_size;
   logic [OW-1:0]     lat_off;
   logic [XLEN-1:0]   ld_data;
   logic [NB+XLEN-1:0] st_lanes;

   // Mirror of load_align: place low-aligned store data and enables in their lanes
   function automatic logic [NB+XLEN-1:0] store_lanes(input logic [XLEN-1:0] wd,
                                                      input logic [OW-1:0]   off,
                                                      input logic [2:0]      sz);
      logic [XLEN-1:0] d;
      logic [NB-1:0]   be;
      case (sz[1:0])
         2'b00:   begin d = XLEN'(wd[7:0]);  be = NB'(1);     end
         2'b01:   begin d = XLEN'(wd[15:0]); be = NB'(3);     end
         2'b10:   begin d = XLEN'(wd[31:0]); be = NB'(4'hF);  end
         default: begin d = wd;              be = '1;         end
      endcase
      return {be << off, d << {off, 3'b000}};
   endfunction

   assign st_lanes  = store_lanes(ex_wdata, ex_addr[OW-1:0], ex_size);
   assign ex_ready  = (state == ST_IDLE);
   assign branch_o  = ex_branch & ex_valid & ex_ready;
   assign jaddr_o   = ex_jaddr;
   assign dbg_state = state;
   assign to_hit    = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

   load_align #(.XLEN(XLEN), .OW(OW)) u_load_align (
      .rdata (mem_rdata),
      .off   (lat_off),
      .size  (lat_size),
      .data  (ld_data)
   );

   always_comb begin
      state_d  = state;
      pass_go  = 1'b0;
      mis_go   = 1'b0;
      acc_go   = 1'b0;
      ack_done = 1'b0;
      to_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ex_valid) begin
               if (!(ex_load || ex_store)) begin
                  pass_go = 1'b1;
               end else if (misaligned(ex_size, ex_addr[2:0])) begin
                  mis_go = 1'b1;
               end else begin
                  acc_go  = 1'b1;
                  state_d = ST_BUSY;
               end
            end
         end
         default: begin
            // An ack in the same cycle as the timeout still completes the access
            if (mem_ack) begin
               ack_done = 1'b1;
               state_d  = ST_IDLE;
            end else if (to_hit) begin
               to_done = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_we        <= 1'b0;
         wb_data      <= '0;
         wb_pc        <= '0;
         wb_exc       <= EXC_NONE;
         lat_store    <= 1'b0;
         lat_regwrite <= 1'b0;
         lat_rd       <= '0;
         lat_pc       <= '0;
         lat_size     <= '0;
         lat_off      <= '0;
      end else begin
         state    <= state_d;
         wb_valid <= 1'b0;
         if (pass_go) begin
            wb_valid <= 1'b1;
            wb_rd    <= ex_rd;
            wb_we    <= ex_regwrite;
            wb_data  <= ex_alu;
            wb_pc    <= ex_pc;
            wb_exc   <= EXC_NONE;
         end
         if (mis_go) begin
            wb_valid <= 1'b1;
            wb_rd    <= ex_rd;
            wb_we    <= 1'b0;
            wb_data  <= '0;
            wb_pc    <= ex_pc;
            wb_exc   <= EXC_MISALIGN;
         end
         if (acc_go) begin
            lat_store    <= ex_store;
            lat_regwrite <= ex_regwrite;
            lat_rd       <= ex_rd;
            lat_pc       <= ex_pc;
            lat_size     <= ex_size;
            lat_off      <= ex_addr[OW-1:0];
            mem_req      <= 1'b1;
            mem_we       <= ex_store;
            mem_addr     <= ex_addr & ~ADDR_W'(NB - 1);
            {mem_be, mem_wdata} <= st_lanes;
            cnt          <= '0;
         end
         if (state == ST_BUSY && !mem_ack && !to_hit && TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
         end
         if (ack_done) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= lat_rd;
            wb_we    <= lat_store ? 1'b0 : lat_regwrite;
            wb_data  <= lat_store ? '0 : ld_data;
            wb_pc    <= lat_pc;
            wb_exc   <= EXC_NONE;
         end
         if (to_done) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= lat_rd;
            wb_we    <= 1'b0;
            wb_data  <= '0;
            wb_pc    <= lat_pc;
            wb_exc   <= EXC_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_p.sv
// Directed bench for mem_stage_p: drivers issue EX bundles and answer the memory
// port; a negedge monitor pops expected MEM/WB results from a queue and compares.
module tb_mem_stage_p;
   import mem_pkg::*;

   localparam int XLEN = 32;
   localparam int TO   = 15;

   logic        CLK, RESET_N;
   logic        ex_valid, ex_ready, ex_load, ex_store;
   logic [2:0]  ex_size;
   logic [31:0] ex_addr, ex_alu, ex_wdata, ex_pc, ex_jaddr, jaddr_o;
   logic [4:0]  ex_rd, wb_rd;
   logic        ex_regwrite, ex_branch, branch_o;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data, wb_pc;
   logic [3:0]  mem_be;
   logic        wb_valid, wb_we;
   logic [1:0]  wb_exc;
   state_e      dbg_state;

   typedef struct packed {
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
      logic [31:0] pc;
      logic [1:0]  exc;
   } wb_t;

   wb_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   mem_stage_p #(.XLEN(XLEN), .ADDR_W(32), .REG_W(5), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
      .ex_size(ex_size), .ex_addr(ex_addr), .ex_alu(ex_alu), .ex_wdata(ex_wdata),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_pc(ex_pc),
      .ex_branch(ex_branch), .ex_jaddr(ex_jaddr), .branch_o(branch_o), .jaddr_o(jaddr_o),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
      .wb_pc(wb_pc), .wb_exc(wb_exc), .dbg_state(dbg_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor
   always @(negedge CLK) begin
      if (RESET_N && wb_valid) begin
         if (exp_q.size() == 0) begin
            check("wb_unexpected", 1, 0);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            check("wb_data", wb_data, e.data);
            check("wb_rd",   wb_rd,   e.rd);
            check("wb_we",   wb_we,   e.we);
            check("wb_pc",   wb_pc,   e.pc);
            check("wb_exc",  wb_exc,  e.exc);
         end
      end
   end

   // driver tasks
   task automatic drive(input logic ld, input logic st, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw, input logic [31:0] pc);
      @(negedge CLK);
      check("ex_ready_idle", ex_ready, 1);
      ex_load = ld; ex_store = st; ex_size = sz; ex_addr = addr; ex_alu = alu;
      ex_wdata = wd; ex_rd = rd; ex_regwrite = rw; ex_pc = pc; ex_valid = 1'b1;
      @(posedge CLK);
      #1;
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
   endtask

   task automatic pass(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                       input logic [31:0] pc);
      exp_q.push_back('{rd: rd, we: rw, data: alu, pc: pc, exc: EXC_NONE});
      drive(1'b0, 1'b0, SZ_W, 32'h0, alu, 32'h0, rd, rw, pc);
      check("pass_no_req", mem_req, 0);
   endtask

   task automatic misalign(input logic [2:0] sz, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] pc);
      exp_q.push_back('{rd: rd, we: 1'b0, data: 32'h0, pc: pc, exc: EXC_MISALIGN});
      drive(1'b1, 1'b0, sz, addr, 32'h0, 32'h0, rd, 1'b1, pc);
      check("mis_no_req", mem_req, 0);
   endtask

   // Issue an aligned access, let mem_ack arrive in BUSY cycle delay+1.
   task automatic access(input logic ld, input logic st, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw, input logic [31:0] pc, input int delay,
                         input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] mwd,
                         input logic [31:0] wbd, input logic wbwe);
      exp_q.push_back('{rd: rd, we: wbwe, data: wbd, pc: pc, exc: EXC_NONE});
      drive(ld, st, sz, addr, 32'h0, wd, rd, rw, pc);
      check("mem_req", mem_req, 1);
      check("mem_addr", mem_addr, addr & ~32'h3);
      check("mem_we", mem_we, st);
      check("ex_ready_busy", ex_ready, 0);
      if (st) begin
         check("mem_be", mem_be, be);
         check("mem_wdata", mem_wdata, mwd);
      end
      ex_valid = 1'b1; ex_branch = 1'b1;
      #1;
      check("branch_busy", branch_o, 0);
      ex_valid = 1'b0; ex_branch = 1'b0;
      for (int i = 0; i < delay; i++) begin
         @(posedge CLK);
         #1;
         check("req_held", mem_req, 1);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge CLK);
      #1;
      mem_ack = 1'b0;
      check("req_drop", mem_req, 0);
      check("ready_back", ex_ready, 1);
   endtask

   task automatic timeout_access(input logic [31:0] addr, input logic [4:0] rd,
                                 input logic [31:0] pc);
      exp_q.push_back('{rd: rd, we: 1'b0, data: 32'h0, pc: pc, exc: EXC_TIMEOUT});
      drive(1'b1, 1'b0, SZ_W, addr, 32'h0, 32'h0, rd, 1'b1, pc);
      for (int i = 0; i < TO - 1; i++) begin
         @(posedge CLK);
         #1;
         check("to_req_held", mem_req, 1);
      end
      @(posedge CLK);
      #1;
      check("to_req_drop", mem_req, 0);
      check("to_ready", ex_ready, 1);
   endtask

   initial begin
      RESET_N = 1'b0; ex_valid = 0; ex_load = 0; ex_store = 0; ex_size = 0; ex_addr = 0;
      ex_alu = 0; ex_wdata = 0; ex_rd = 0; ex_regwrite = 0; ex_pc = 0; ex_branch = 0;
      ex_jaddr = 0; mem_ack = 0; mem_rdata = 0;
      repeat (3) @(negedge CLK);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_ex_ready", ex_ready, 1);
      check("rst_state", dbg_state, ST_IDLE);
      RESET_N = 1'b1;

      pass(32'h1234, 5'd5, 1'b1, 32'h40);
      // ack in third BUSY cycle
      access(1, 0, SZ_B,  32'h103, 0, 5'd6, 1, 32'h44, 2, 32'h80FF_FFFF, 0, 0, 32'hFFFF_FF80, 1);
      access(1, 0, SZ_BU, 32'h103, 0, 5'd7, 1, 32'h48, 2, 32'h80FF_FFFF, 0, 0, 32'h0000_0080, 1);
      access(0, 1, SZ_H,  32'h102, 32'hABCD, 5'd8, 1, 32'h4C, 1, 0, 4'b1100, 32'hABCD_0000, 0, 0);
      access(1, 0, SZ_W,  32'h104, 0, 5'd9, 1, 32'h50, 0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 1);
      access(1, 0, SZ_H,  32'h102, 0, 5'd10, 1, 32'h54, 1, 32'h8001_1234, 0, 0, 32'hFFFF_8001, 1);
      access(1, 0, SZ_HU, 32'h102, 0, 5'd11, 1, 32'h58, 1, 32'h8001_1234, 0, 0, 32'h0000_8001, 1);
      access(0, 1, SZ_B,  32'h101, 32'h1FF, 5'd12, 1, 32'h5C, 0, 0, 4'b0010, 32'h0000_FF00, 0, 0);
      // load and store together behaves as a store
      access(1, 1, SZ_W,  32'h108, 32'h1234_5678, 5'd13, 1, 32'h60, 1, 32'hFFFF_FFFF, 4'b1111,
             32'h1234_5678, 0, 0);
      access(1, 0, SZ_W,  32'h10C, 0, 5'd14, 0, 32'h64, 0, 32'h55, 0, 0, 32'h55, 0);
      misalign(SZ_W, 32'h101, 5'd15, 32'h68);
      misalign(SZ_H, 32'h103, 5'd16, 32'h6C);
      timeout_access(32'h200, 5'd17, 32'h70);
      // ack in the last allowed cycle completes normally
      access(1, 0, SZ_W, 32'h204, 0, 5'd18, 1, 32'h74, TO - 1, 32'hCAFE_F00D, 0, 0,
             32'hCAFE_F00D, 1);

      // branch in IDLE on a pass-through instruction
      exp_q.push_back('{rd: 5'd1, we: 1'b0, data: 32'h99, pc: 32'h78, exc: EXC_NONE});
      @(negedge CLK);
      ex_valid = 1; ex_branch = 1; ex_jaddr = 32'h800; ex_alu = 32'h99; ex_rd = 5'd1;
      ex_regwrite = 0; ex_pc = 32'h78;
      #1;
      check("branch_idle", branch_o, 1);
      check("jaddr", jaddr_o, 32'h800);
      @(posedge CLK);
      #1;
      ex_valid = 0; ex_branch = 0;

      // reset during BUSY abandons the access
      drive(1'b1, 1'b0, SZ_W, 32'h300, 32'h0, 32'h0, 5'd20, 1'b1, 32'h80);
      @(posedge CLK);
      #2;
      RESET_N = 1'b0;
      #1;
      check("arst_req", mem_req, 0);
      check("arst_addr", mem_addr, 0);
      check("arst_state", dbg_state, ST_IDLE);
      check("arst_ready", ex_ready, 1);
      check("arst_wb_pc", wb_pc, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(posedge CLK);
      #1;
      mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
      @(posedge CLK);
      #1;
      mem_ack = 1'b0;
      check("late_ack_wb", wb_valid, 0);
      check("late_ack_req", mem_req, 0);
      pass(32'h5A5A, 5'd21, 1'b1, 32'h84);

      repeat (3) @(negedge CLK);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_p.md
# mem_stage_p

Parameterised memory-access pipeline stage between EX and WB of the in-order core. It replaces the fixed single-cycle MEM stage with a handshake-driven data-memory port, supports sized and sign-extended loads, byte-enabled stores, misalignment and bus-timeout detection, and stalls EX while an access is outstanding. Non-memory instructions pass through to the MEM/WB register in one cycle.

## Interface
- XLEN, 32, data/register width; 32 or 64 only
- ADDR_W, 32, byte-address width
- REG_W, 5, destination register index width
- TIMEOUT, 15, max cycles waiting for mem_ack before bus error; 0 disables
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX/MEM bundle valid
- ex_ready  out  1  stage accepts bundle this cycle
- ex_load, ex_store  in  1 each  access type; both 0 = pass-through; both 1 treated as store
- ex_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D (XLEN=64), 100 BU, 101 HU, 110 WU (XLEN=64)
- ex_addr  in  ADDR_W  effective address (ALU result)
- ex_alu  in  XLEN  ALU result for pass-through writeback
- ex_wdata  in  XLEN  store data, low-aligned
- ex_rd  in  REG_W  destination register
- ex_regwrite  in  1  writeback enable
- ex_pc  in  32  instruction PC
- ex_branch  in  1  branch taken; ex_jaddr  in  32  target
- branch_o  out  1  ex_branch & ex_valid & ex_ready (combinational)
- jaddr_o  out  32  ex_jaddr (combinational)
- mem_req  out  1  access request, held until mem_ack
- mem_we  out  1  store
- mem_addr  out  ADDR_W  address aligned down to XLEN/8 bytes
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  store data shifted into lane position
- mem_ack  in  1  access complete (one-cycle pulse)
- mem_rdata  in  XLEN  full aligned word, valid with mem_ack
- wb_valid  out  1  MEM/WB register valid
- wb_rd  out  REG_W; wb_we  out  1; wb_data  out  XLEN; wb_pc  out  32
- wb_exc  out  2  00 none, 01 misaligned, 10 bus timeout

## Operation
- States: IDLE, BUSY.
- IDLE: ex_ready=1. On ex_valid:
  - pass-through: MEM/WB loaded with ex_alu, ex_rd, ex_regwrite, ex_pc; wb_valid=1 next cycle.
  - access with addr misaligned to size (H: bit0, W: bits1:0, D: bits2:0): no request; WB loaded with wb_exc=01, wb_we=0.
  - aligned access: latch bundle, assert mem_req, go BUSY; wb_valid=0 next cycle.
- BUSY: ex_ready=0; mem_req/we/addr/be/wdata stable. On mem_ack: load data = lane selected by low address bits, sign- or zero-extended per ex_size; store wb_data=0 and wb_we=0; load wb_we=latched regwrite; wb_valid=1; to IDLE. mem_ack in IDLE is ignored.
- Timeout counter cleared on BUSY entry, increments each BUSY cycle without ack; reaching TIMEOUT: drop mem_req, WB loaded with wb_exc=10, wb_we=0, to IDLE. Ack on the same cycle as timeout wins.
- wb_valid is a one-cycle pulse per accepted instruction; WB always accepts.
- Store lanes: B one enable, H two, W four, D all eight; unused bytes of mem_wdata are don't-care but driven 0.

## Timing
- Pass-through/misaligned: ex accepted at edge N, wb_valid high in cycle N+1.
- Access: mem_req high from N+1; ack in cycle M -> wb_valid in M+1, ex_ready high again in M+1. Minimum load latency 2 cycles.
- Reset (any time, including BUSY): state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_we=0, wb_exc=00, wb_rd=0, wb_data=0, wb_pc=0, counter 0. An outstanding access is abandoned; late mem_ack ignored.
- branch_o/jaddr_o are not registered; valid only while ex_ready=1.

## Structure
- Shared package mem_pkg: size encodings, exc codes, state enum, XLEN-derived byte-lane count.
- One sub-module load_align: (rdata, addr low bits, size) -> extended load data; purely combinational, reused for store lane shifting by a mirrored function.

## Test plan
- Pass-through ex_alu=0x1234, rd=5 -> wb_valid next cycle, wb_data=0x1234, wb_rd=5, wb_we=1, no mem_req.
- LB addr=0x103, mem_rdata=0x80FF_FFFF ack after 3 cycles -> mem_addr=0x100, wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080; ex_ready low throughout BUSY.
- SH addr=0x102, wdata=0xABCD -> mem_be=1100, mem_wdata=0xABCD_0000, wb_we=0.
- LW addr=0x101 -> no mem_req, wb_exc=01 next cycle.
- No ack for TIMEOUT=15 cycles -> mem_req drops, wb_exc=10; ack on cycle 15 -> normal completion.
- RESET_N low during BUSY -> all outputs reset asynchronously; ack after release ignored; next instruction processed normally; branch_o follows ex_branch only in IDLE.
